data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Word-addressed data memory that acts as the responding end of the load/store request interface driven by the multicycle CPU's memory-access states. It accepts one read or write request at a time, inserts a configurable number of wait states, then returns a single-cycle `ready` pulse together with read data or an error flag. It sits beside the instruction memory and is the target of the datapath's MemRead/MemWrite accesses.

## Interface
- `ADDR_W`, default 8: word-address bits; memory depth is 2^ADDR_W words of 32 bits.
- `LATENCY`, default 2: wait states between acceptance and response; legal range 0..15.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-low. The block resets on the rising edge of `clk` while `rst`=0.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; captured with `req`.
- `addr`  in  32  byte address; captured with `req`.
- `wdata`  in  32  write data; captured with `req`.
- `ready`  out  1  one-cycle response pulse.
- `rdata`  out  32  read data; valid while `ready`=1.
- `err`  out  1  response is an error; valid while `ready`=1.

## Operation
- Storage: `mem[0 .. 2^ADDR_W-1]`, 32 bits per word. Reset does not clear it. In simulation it initialises to all zeros.
- Internal registers: `a_q`, `we_q`, `wd_q`, a 4-bit down-counter `cnt`, and a state register.
- States:
  - IDLE: `ready`=0. If `req`=1 at a clock edge, capture `addr`, `we` and `wdata`. Go to BUSY with `cnt`=LATENCY if LATENCY>0; if LATENCY=0, go straight to DONE with the access performed.
  - BUSY: at each edge, if `cnt`>1 then decrement `cnt`; if `cnt`=1 then go to DONE and perform the access.
  - DONE: `ready`=1 for exactly one cycle. Go to IDLE at the next edge unconditionally.
- Requests: `req` is ignored in BUSY and DONE. A request held high through DONE is accepted on the first IDLE edge. A new request is therefore never accepted in the same cycle as the `ready` pulse.
- Address check: a captured address is illegal if `a_q[1:0]`≠0 or `a_q[31:ADDR_W+2]`≠0. The word index is `a_q[ADDR_W+1:2]`.
- Performing the access, on the edge that enters DONE:
  - Legal write: `mem[index]` ← `wd_q`; `rdata` ← 0; `err` ← 0.
  - Legal read: `rdata` ← `mem[index]` (registered); `err` ← 0.
  - Illegal address: no memory update; `rdata` ← 0; `err` ← 1.
- Output hold: `rdata` and `err` keep their values after `ready` falls until the next access is performed. Consumers must qualify both with `ready`.
- Reset values: state=IDLE, `ready`=0, `rdata`=0, `err`=0, `cnt`=0.
- Reset mid-operation: reset in BUSY aborts the transaction; no write is committed and no `ready` pulse follows. Reset in DONE drops `ready` at that edge; a write already committed at DONE entry stays in memory.

## Timing
- A request is accepted at edge E0. `ready` is high during the cycle that follows edge E0+LATENCY.
  - LATENCY=0: `ready` is high in the cycle right after acceptance.
  - LATENCY=2: `ready` is high after the second edge following acceptance.
- Throughput: one transaction per LATENCY+2 cycles when `req` is held high continuously.
- Read-after-write to the same word, issued as the next transaction, returns the newly written value.
- `ready`, `rdata` and `err` are all registered outputs; there is no combinational path from inputs to outputs.

## Test plan
- Reset (`rst`=0) for 2 cycles with `req`=1 -> `ready`=0, `rdata`=0, `err`=0 throughout; no transaction starts.
- LATENCY=2: write `addr`=0x10, `wdata`=0xDEADBEEF, then read `addr`=0x10 -> the write `ready` appears 2 cycles after acceptance with `err`=0; the read `ready` shows `rdata`=0xDEADBEEF, `err`=0.
- Misaligned write to `addr`=0x13, then read 0x10 -> the first response has `err`=1 and `rdata`=0; the read still returns 0xDEADBEEF.
- Out-of-range read, `addr`=0x400 with ADDR_W=8 -> `ready` with `err`=1, `rdata`=0.
- `req` held high through four back-to-back reads, LATENCY=0 -> `ready` pulses every 2nd cycle, never on 2 consecutive cycles.
- Write to 0x20 with 0x12345678, `rst`=0 asserted while in BUSY, then read 0x20 after reset -> no `ready` for the aborted write; the read returns the prior contents (0).

Source files
------------

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Load/store request bus between the CPU memory-access states (master) and
// the data memory responder (slave).
//   req    master->slave  request strobe, sampled only while the slave is idle
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  32-bit byte address
//   wdata  master->slave  32-bit write data
//   ready  slave->master  one-cycle response pulse
//   rdata  slave->master  read data, valid while ready=1
//   err    slave->master  error flag, valid while ready=1
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Word-addressed 32-bit data memory answering one load/store request at a
// time. After acceptance it waits LATENCY cycles (0..15), performs the access
// and raises ready for exactly one cycle with registered rdata/err.
// Parameters:
//   ADDR_W   word-address bits; depth is 2**ADDR_W words (ADDR_W <= 29)
//   LATENCY  wait states between acceptance and response, 0..15
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   request/response bus (slave side)
// Memory contents are not affected by reset.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  state_t      state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic [31:0] a_q;
  logic        we_q;
  logic [31:0] wd_q;
  logic [31:0] rdataQ;
  logic        errQ;

  logic        capture;
  logic        perform;

  // With LATENCY=0 the access is performed on the accepting edge, so the
  // request fields must come straight from the bus rather than the capture
  // registers (which only load on that same edge).
  logic [31:0]       accAddr;
  logic              accWe;
  logic [31:0]       accWdata;
  logic              accLegal;
  logic [ADDR_W-1:0] accIndex;

  always_comb begin
    if (state == IDLE) begin
      accAddr  = bus.addr;
      accWe    = bus.we;
      accWdata = bus.wdata;
    end else begin
      accAddr  = a_q;
      accWe    = we_q;
      accWdata = wd_q;
    end
  end

  assign accLegal = (accAddr[1:0] == 2'b00) &&
                    ((accAddr >> (ADDR_W + 2)) == '0);
  assign accIndex = accAddr[ADDR_W+1:2];

  // Next-state and control decode
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    capture   = 1'b0;
    perform   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            stateNext = DONE;
            perform   = 1'b1;
          end else begin
            stateNext = BUSY;
            cntNext   = 4'(LATENCY);
          end
        end
      end
      BUSY: begin
        if (cnt > 4'd1) begin
          cntNext = cnt - 4'd1;
        end else begin
          // cnt==1 is the normal exit; cnt==0 cannot occur but is not a trap
          stateNext = DONE;
          cntNext   = '0;
          perform   = 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // State, capture and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      we_q   <= 1'b0;
      wd_q   <= '0;
      rdataQ <= '0;
      errQ   <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (capture) begin
        a_q  <= bus.addr;
        we_q <= bus.we;
        wd_q <= bus.wdata;
      end
      if (perform) begin
        if (!accLegal) begin
          rdataQ <= '0;
          errQ   <= 1'b1;
        end else if (accWe) begin
          rdataQ <= '0;
          errQ   <= 1'b0;
        end else begin
          rdataQ <= mem[accIndex];
          errQ   <= 1'b0;
        end
      end
    end
  end

  // Storage: no reset; a reset edge suppresses the commit so an aborted
  // write never lands.
  always_ff @(posedge clk) begin
    if (rst && perform && accLegal && accWe) begin
      mem[accIndex] <= accWdata;
    end
  end

  assign bus.ready = (state == DONE);
  assign bus.rdata = rdataQ;
  assign bus.err   = errQ;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder: one instance with LATENCY=2 and one
// with LATENCY=0, each on its own bus interface, sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  data_mem_responder_if b2 ();
  data_mem_responder_if b0 ();

  data_mem_responder #(.ADDR_W(8), .LATENCY(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic selReady(input bit sel0);
    return sel0 ? b0.ready : b2.ready;
  endfunction

  // Issue one request on the selected bus and check response latency,
  // payload, and that ready lasts exactly one cycle.
  task automatic txn(input string tag, input bit sel0, input bit w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] expRd, input logic expErr,
                     input int expLat);
    int n;
    @(posedge clk); #1;
    if (sel0) begin
      b0.req = 1'b1; b0.we = w; b0.addr = a; b0.wdata = d;
    end else begin
      b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = d;
    end
    @(posedge clk); #1;             // accepting edge has passed
    b0.req = 1'b0;
    b2.req = 1'b0;
    n = 0;
    while (!selReady(sel0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".lat"}, 32'(n), 32'(expLat));
    check({tag, ".rdata"}, sel0 ? b0.rdata : b2.rdata, expRd);
    check({tag, ".err"}, 32'(sel0 ? b0.err : b2.err), 32'(expErr));
    @(posedge clk); #1;
    check({tag, ".pulse"}, 32'(selReady(sel0)), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h10; b2.wdata = 32'hFFFF_FFFF;
    b0.req = 1'b1; b0.we = 1'b1; b0.addr = 32'h10; b0.wdata = 32'hFFFF_FFFF;

    // Reset held two cycles with req asserted
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst.ready2", 32'(b2.ready), 32'd0);
      check("rst.rdata2", b2.rdata, 32'd0);
      check("rst.err2", 32'(b2.err), 32'd0);
      check("rst.ready0", 32'(b0.ready), 32'd0);
      check("rst.err0", 32'(b0.err), 32'd0);
    end
    b2.req = 1'b0;
    b0.req = 1'b0;
    rst = 1'b1;
    // No transaction may have started during reset
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("postrst.ready2", 32'(b2.ready), 32'd0);
      check("postrst.ready0", 32'(b0.ready), 32'd0);
    end

    // LATENCY=2: write then read-after-write
    txn("wr10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    txn("rd10", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

    // Misaligned write is rejected and leaves memory alone
    txn("wr13", 1'b0, 1'b1, 32'h13, 32'h1111_2222, 32'h0, 1'b1, 2);
    txn("rd10b", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

    // Out of range for ADDR_W=8 (word 256)
    txn("rd400", 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 2);
    // Highest legal word, and a read that clears err again
    txn("wr3fc", 1'b0, 1'b1, 32'h3FC, 32'hCAFE_0001, 32'h0, 1'b0, 2);
    txn("rd3fc", 1'b0, 1'b0, 32'h3FC, 32'h0, 32'hCAFE_0001, 1'b0, 2);

    // LATENCY=0: access performed on the accepting edge
    txn("z.wr04", 1'b1, 1'b1, 32'h04, 32'hA5A5_0F0F, 32'h0, 1'b0, 0);
    txn("z.rd04", 1'b1, 1'b0, 32'h04, 32'h0, 32'hA5A5_0F0F, 1'b0, 0);
    txn("z.rd13", 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 0);

    // LATENCY=0: req held high for four back-to-back reads of word 1
    @(posedge clk); #1;
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 32'h04; b0.wdata = 32'h0;
    begin
      int pulses;
      logic prev;
      pulses = 0;
      prev = 1'b0;
      for (int i = 0; i < 9; i++) begin
        @(posedge clk); #1;
        check($sformatf("b2b.ready[%0d]", i), 32'(b0.ready), 32'((i % 2 == 0) && (i < 8)));
        if (b0.ready) begin
          pulses++;
          check($sformatf("b2b.rdata[%0d]", i), b0.rdata, 32'hA5A5_0F0F);
          check($sformatf("b2b.consec[%0d]", i), 32'(prev), 32'd0);
        end
        prev = b0.ready;
        if (i == 6) b0.req = 1'b0;  // fourth accept is in DONE; stop here
      end
      check("b2b.pulses", 32'(pulses), 32'd4);
    end

    // Reset during BUSY aborts a write; word 8 is first set to a known 0
    txn("wr20init", 1'b0, 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 2);
    @(posedge clk); #1;
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h20; b2.wdata = 32'h1234_5678;
    @(posedge clk); #1;             // accepted, now in BUSY
    b2.req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort.ready[%0d]", i), 32'(b2.ready), 32'd0);
      @(posedge clk); #1;
    end
    txn("rd20", 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
